// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand loader and diagonal skewer for the systolic matrix-multiply array
module systolic_feeder #(
  parameter int SIZE   = 8,
  parameter int I_BITS = 8,
  parameter int FLUSH  = SIZE
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [SIZE*I_BITS-1:0] i_a_row,
  input  logic [SIZE*I_BITS-1:0] i_b_col,
  output logic                   o_array_clear,
  output logic [SIZE*I_BITS-1:0] o_a_full,
  output logic [SIZE*I_BITS-1:0] o_b_full,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int KW = $clog2(SIZE + 1);
  localparam int TW = $clog2(2 * SIZE);
  localparam int FW = $clog2(FLUSH + 1);
  localparam int IW = $clog2(SIZE);

  localparam logic [KW-1:0] K_LAST = KW'(SIZE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * SIZE - 2);
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [KW-1:0] k;
  logic [TW-1:0] t;
  logic [FW-1:0] f;
  logic          accept;

  // a_bank[r] is row r of A packed by column; b_bank[c] is column c of B packed by row.
  logic [SIZE*I_BITS-1:0] a_bank [SIZE];
  logic [SIZE*I_BITS-1:0] b_bank [SIZE];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    o_ready       = 1'b0;
    o_array_clear = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    accept        = 1'b0;
    unique case (state)
      S_LOAD: begin
        o_ready = 1'b1;
        accept  = i_valid;
        if (i_valid && (k == K_LAST)) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        o_array_clear = 1'b1;
        o_busy        = 1'b1;
        state_n       = S_FEED;
      end
      S_FEED: begin
        o_busy = 1'b1;
        if (t == T_LAST) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        o_busy = 1'b1;
        if (f == F_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_n = S_LOAD;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      k <= '0;
      t <= '0;
      f <= '0;
    end else begin
      if (accept) begin
        k <= k + KW'(1);
      end else if (state == S_DONE) begin
        k <= '0;
      end
      t <= (state == S_FEED)  ? t + TW'(1) : '0;
      f <= (state == S_FLUSH) ? f + FW'(1) : '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a_bank <= '{default: '0};
      b_bank <= '{default: '0};
    end else if (accept) begin
      a_bank[k[IW-1:0]] <= i_a_row;
      b_bank[k[IW-1:0]] <= i_b_col;
    end
  end

  // Lane q lags by q beats: row q of the array sees A[q][t-q], column q sees B[t-q][q].
  for (genvar q = 0; q < SIZE; q++) begin : g_lane
    logic [TW-1:0]     dl;
    logic [I_BITS-1:0] a_lane;
    logic [I_BITS-1:0] b_lane;

    always_comb begin
      dl     = t - TW'(q);
      a_lane = '0;
      b_lane = '0;
      if ((state == S_FEED) && (t >= TW'(q)) && (dl < TW'(SIZE))) begin
        a_lane = a_bank[q][dl[IW-1:0]*I_BITS +: I_BITS];
        b_lane = b_bank[q][dl[IW-1:0]*I_BITS +: I_BITS];
      end
    end

    assign o_a_full[I_BITS*q +: I_BITS] = a_lane;
    assign o_b_full[I_BITS*q +: I_BITS] = b_lane;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder at SIZE=2
module tb_systolic_feeder;
  localparam int SZ = 2;
  localparam int IB = 8;
  localparam int FL = SZ;
  localparam int W  = SZ * IB;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_a_row = '0;
  logic [W-1:0] i_b_col = '0;
  logic         o_ready;
  logic         o_array_clear;
  logic [W-1:0] o_a_full;
  logic [W-1:0] o_b_full;
  logic         o_busy;
  logic         o_done;

  systolic_feeder #(.SIZE(SZ), .I_BITS(IB), .FLUSH(FL)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_a_row       (i_a_row),
    .i_b_col       (i_b_col),
    .o_array_clear (o_array_clear),
    .o_a_full      (o_a_full),
    .o_b_full      (o_b_full),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    logic         clr;
    logic         done;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   first_acc;
  int   last_acc;

  logic [IB-1:0] ja [SZ][SZ];
  logic [IB-1:0] jb [SZ][SZ];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  function automatic exp_t mk(input logic clr, input logic done, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int c);
    exp_t e;
    e.clr  = clr;
    e.done = done;
    e.a    = a;
    e.b    = b;
    e.cyc  = c;
    return e;
  endfunction

  // Expected stream from the matrices in ja/jb, given the cycle of the last accept.
  task automatic push_model(input int e);
    logic [W-1:0] a, b;
    q.push_back(mk(1'b1, 1'b0, '0, '0, e + 1));
    for (int t = 0; t <= 2*SZ-2; t++) begin
      a = '0;
      b = '0;
      for (int r = 0; r < SZ; r++) begin
        if (t - r >= 0 && t - r < SZ) begin
          a[IB*r +: IB] = ja[r][t-r];
          b[IB*r +: IB] = jb[t-r][r];
        end
      end
      q.push_back(mk(1'b0, 1'b0, a, b, e + 2 + t));
    end
    for (int i = 0; i < FL; i++) q.push_back(mk(1'b0, 1'b0, '0, '0, e + 2*SZ + 1 + i));
    q.push_back(mk(1'b0, 1'b1, '0, '0, e + 2*SZ + 1 + FL));
  endtask

  // Hand-computed stream for A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  task automatic push_hand(input int e);
    q.push_back(mk(1'b1, 1'b0, 16'h0000, 16'h0000, e + 1));
    q.push_back(mk(1'b0, 1'b0, 16'h0001, 16'h0005, e + 2));
    q.push_back(mk(1'b0, 1'b0, 16'h0302, 16'h0607, e + 3));
    q.push_back(mk(1'b0, 1'b0, 16'h0400, 16'h0800, e + 4));
    q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, e + 5));
    q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, e + 6));
    q.push_back(mk(1'b0, 1'b1, 16'h0000, 16'h0000, e + 7));
  endtask

  always @(negedge i_clock) begin
    if (i_reset) begin
      if (o_busy || o_done || o_array_clear) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output at cycle %0d: busy=%0b done=%0b clear=%0b, required idle",
                   cyc, o_busy, o_done, o_array_clear);
        end else begin
          me = q.pop_front();
          check("out_cycle", 64'(cyc), 64'(me.cyc));
          check("clear", 64'(o_array_clear), 64'(me.clr));
          check("done", 64'(o_done), 64'(me.done));
          check("a_full", 64'(o_a_full), 64'(me.a));
          check("b_full", 64'(o_b_full), 64'(me.b));
          check("busy", 64'(o_busy), 64'(!me.done));
          check("ready_busy", 64'(o_ready), 64'(0));
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_output at cycle %0d: got idle, required beat for cycle %0d", cyc, q[0].cyc);
          me = q.pop_front();
        end
        check("idle_ready", 64'(o_ready), 64'(1));
        check("idle_a", 64'(o_a_full), 64'(0));
        check("idle_b", 64'(o_b_full), 64'(0));
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        ja[i][j] = IB'($urandom_range(1, 255));
        jb[i][j] = IB'($urandom_range(1, 255));
      end
  endtask

  // Called just after a negedge; returns just after the negedge following the last accept.
  task automatic load_job(input int gap, input bit hold, input bit hand);
    int w;
    for (int k = 0; k < SZ; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          i_valid = 1'b0;
          i_a_row = W'($urandom);
          i_b_col = W'($urandom);
          @(negedge i_clock);
        end
      end
      i_valid = 1'b1;
      for (int j = 0; j < SZ; j++) begin
        i_a_row[IB*j +: IB] = ja[k][j];
        i_b_col[IB*j +: IB] = jb[j][k];
      end
      w = 0;
      while (!o_ready && w < 100) begin
        @(negedge i_clock);
        w++;
      end
      if (!o_ready) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout at cycle %0d: o_ready=0, required 1 within 100 cycles", cyc);
      end
      if (k == 0) first_acc = cyc;
      last_acc = cyc;
      if (k == SZ - 1) begin
        if (hand) push_hand(cyc);
        else push_model(cyc);
      end
      @(negedge i_clock);
    end
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge i_clock);
      w++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout at cycle %0d: %0d beats outstanding, required 0", cyc, q.size());
      q.delete();
    end
    repeat (2) @(negedge i_clock);
  endtask

  initial begin
    int e1;
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_a_row = 16'hBEEF;
    i_b_col = 16'h1234;
    repeat (3) @(negedge i_clock);
    check("rst_ready", 64'(o_ready), 64'(1));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_clear", 64'(o_array_clear), 64'(0));
    check("rst_a", 64'(o_a_full), 64'(0));
    check("rst_b", 64'(o_b_full), 64'(0));
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clock);

    ja = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    jb = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    load_job(0, 1'b0, 1'b1);
    wait_drain();

    fill_rand();
    load_job(2, 1'b0, 1'b0);
    wait_drain();

    fill_rand();
    load_job(0, 1'b1, 1'b0);
    e1 = last_acc;
    fill_rand();
    load_job(0, 1'b0, 1'b0);
    check("b2b_accept_gap", 64'(first_acc - e1), 64'(2*SZ + 2 + FL));
    wait_drain();

    fill_rand();
    load_job(0, 1'b0, 1'b0);
    e1 = last_acc;
    while (cyc < e1 + 3) @(negedge i_clock);
    #2 i_reset = 1'b0;
    q.delete();
    #1;
    check("abort_a", 64'(o_a_full), 64'(0));
    check("abort_b", 64'(o_b_full), 64'(0));
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_ready", 64'(o_ready), 64'(1));
    @(negedge i_clock);
    i_reset = 1'b1;
    for (int i = 0; i < 2*SZ + FL + 4; i++) begin
      @(negedge i_clock);
      check("abort_no_done", 64'(o_done), 64'(0));
    end

    fill_rand();
    load_job(0, 1'b0, 1'b0);
    wait_drain();

    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        ja[i][j] = 8'hFF;
        jb[i][j] = (i == j) ? 8'h80 : 8'h01;
      end
    load_job(1, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
